// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared state encoding and default timing constants for the PLL reset sequencer
package pll_seq_pkg;
  typedef enum logic [2:0] {PLL_RST, WAIT_LOCK, STABLE, RUN, FAULT} state_t;
  localparam int DEF_RST_CYCLES = 16;
  localparam int DEF_LOCK_TIMEOUT = 4096;
  localparam int DEF_STABLE_CYCLES = 256;
  localparam int DEF_MAX_RETRIES = 3;
  localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/pll_reset_sequencer_bit_sync.sv
// bit_sync: two-flop synchronizer with synchronous active-low clear
module bit_sync (
  input  logic clk,
  input  logic sresetn,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk) {q, meta} <= sresetn ? {meta, d} : 2'b00;
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: PLL reset / lock-wait / stabilise / run sequencer with retry, fault and lock-loss counting
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       sresetn,
  input  logic       locked,
  input  logic       relock_req,
  output logic       pll_resetb,
  output logic       sys_resetn,
  output logic       ready,
  output logic       fault,
  output logic [7:0] lock_loss_count
);
  localparam int RW = $clog2(MAX_RETRIES + 2);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);
  logic lock_s;
  logic loss;
  state_t st, st_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [RW-1:0] retry, retry_n;
  bit_sync u_lock_sync (
    .clk(clk),
    .sresetn(sresetn),
    .d(locked),
    .q(lock_s)
  );
  assign loss = (st == RUN) && !lock_s;
  always_comb begin
    st_n = st;
    cnt_n = cnt + CNT_W'(1);
    retry_n = retry;
    case (st)
      PLL_RST: begin
        st_n = (cnt == RST_LAST) ? WAIT_LOCK : PLL_RST;
        cnt_n = (cnt == RST_LAST) ? '0 : cnt + CNT_W'(1);
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          st_n = STABLE;
          cnt_n = '0;
        end else if (cnt == TO_LAST) begin
          st_n = (retry == RETRY_MAX) ? FAULT : PLL_RST;
          retry_n = (retry == RETRY_MAX) ? retry : retry + RW'(1);
          cnt_n = '0;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          st_n = WAIT_LOCK;
          cnt_n = '0;
        end else if (cnt == ST_LAST) begin
          st_n = RUN;
          cnt_n = '0;
          retry_n = '0;
        end
      end
      RUN: begin
        st_n = (!lock_s || relock_req) ? PLL_RST : RUN;
        cnt_n = '0;
      end
      FAULT: begin
        st_n = relock_req ? PLL_RST : FAULT;
        retry_n = relock_req ? '0 : retry;
        cnt_n = '0;
      end
      default: begin
        st_n = PLL_RST;
        cnt_n = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!sresetn) begin
      st <= PLL_RST;
      cnt <= '0;
      retry <= '0;
      pll_resetb <= 1'b0;
      sys_resetn <= 1'b0;
      ready <= 1'b0;
      fault <= 1'b0;
      lock_loss_count <= '0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      retry <= retry_n;
      pll_resetb <= !(st_n == PLL_RST || st_n == FAULT);
      sys_resetn <= st_n == RUN;
      ready <= st_n == RUN;
      fault <= st_n == FAULT;
      lock_loss_count <= lock_loss_count + 8'(loss && lock_loss_count != 8'hFF);
    end
  end
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: randomized scoreboard bench predicting output change events from the sequencing rules
module tb_pll_reset_sequencer;
  localparam int RST = 4;
  localparam int LT = 32;
  localparam int S = 8;
  localparam int MR = 2;
  typedef struct {
    int t;
    logic [11:0] v;
  } ev_t;
  logic clk = 1'b0;
  logic sresetn = 1'b0;
  logic locked = 1'b0;
  logic relock_req = 1'b0;
  logic pll_resetb, sys_resetn, ready, fault;
  logic [7:0] lock_loss_count;
  ev_t q[$];
  ev_t e;
  logic [11:0] cur, prev, obs;
  int cyc = 0;
  int checks = 0;
  int fails = 0;
  int cnt_m = 0;
  int run_t = 0;
  bit mon_en = 1'b0;
  pll_reset_sequencer #(
    .RST_CYCLES(RST),
    .LOCK_TIMEOUT(LT),
    .STABLE_CYCLES(S),
    .MAX_RETRIES(MR),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .sresetn(sresetn),
    .locked(locked),
    .relock_req(relock_req),
    .pll_resetb(pll_resetb),
    .sys_resetn(sys_resetn),
    .ready(ready),
    .fault(fault),
    .lock_loss_count(lock_loss_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    obs = {pll_resetb, sys_resetn, ready, fault, lock_loss_count};
    if (mon_en && obs !== prev) begin
      checks++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_change cyc=%0d got=%h expected no change", cyc, obs);
      end else begin
        e = q.pop_front();
        if (e.t != cyc || e.v !== obs) begin
          fails++;
          $display("FAIL event got cyc=%0d val=%h expected cyc=%0d val=%h", cyc, obs, e.t, e.v);
        end
      end
    end
    prev = obs;
  end
  function automatic logic [11:0] vec(bit p, bit s, bit r, bit f, int c);
    return {p, s, r, f, 8'(c)};
  endfunction
  task automatic push(int t, logic [11:0] v);
    if (v !== cur) begin
      q.push_back('{t, v});
      cur = v;
    end
  endtask
  task automatic step;
    @(negedge clk);
  endtask
  task automatic wait_until(int t);
    while (cyc < t) @(negedge clk);
  endtask
  task automatic chk(string name, logic [7:0] got, logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask
  task automatic drain(string name);
    int n = 0;
    while (q.size() > 0 && n < 200) begin
      step;
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain_%s pending=%0d expected 0 (next at cyc %0d)", name, q.size(), q[0].t);
      q.delete();
    end
  endtask
  task automatic reset_pulse(output int k);
    sresetn = 1'b0;
    k = cyc + 1;
    cnt_m = 0;
    push(k, vec(0, 0, 0, 0, 0));
    step;
    sresetn = 1'b1;
    push(k + RST, vec(1, 0, 0, 0, 0));
  endtask
  task automatic pulse_relock(int t);
    wait_until(t);
    relock_req = 1'b1;
    step;
    relock_req = 1'b0;
  endtask
  task automatic run_drop(bit rq);
    int d, h;
    d = (cyc > run_t ? cyc : run_t) + int'($urandom_range(3, 0));
    wait_until(d);
    locked = 1'b0;
    cnt_m = cnt_m < 255 ? cnt_m + 1 : 255;
    push(d + 3, vec(0, 0, 0, 0, cnt_m));
    push(d + 3 + RST, vec(1, 0, 0, 0, cnt_m));
    run_t = d + 4 + RST + S;
    push(run_t, vec(1, 1, 1, 0, cnt_m));
    h = rq ? 3 : int'($urandom_range(4, 1));
    if (rq) pulse_relock(d + 2);
    wait_until(d + h);
    locked = 1'b1;
  endtask
  task automatic relock_enter(output int qt);
    qt = (cyc > run_t ? cyc : run_t) + int'($urandom_range(3, 0));
    wait_until(qt);
    relock_req = 1'b1;
    push(qt + 1, vec(0, 0, 0, 0, cnt_m));
    push(qt + 1 + RST, vec(1, 0, 0, 0, cnt_m));
    step;
    relock_req = 1'b0;
  endtask
  initial begin
    #3000000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end
  initial begin
    int k, l, d, w, r, qt;
    repeat (3) step;
    chk("rst_pll_resetb", {7'd0, pll_resetb}, 8'd0);
    chk("rst_sys_resetn", {7'd0, sys_resetn}, 8'd0);
    chk("rst_ready", {7'd0, ready}, 8'd0);
    chk("rst_fault", {7'd0, fault}, 8'd0);
    chk("rst_count", lock_loss_count, 8'd0);
    cur = vec(0, 0, 0, 0, 0);
    mon_en = 1'b1;
    k = cyc;
    sresetn = 1'b1;
    push(k + RST, vec(1, 0, 0, 0, 0));
    l = k + 10;
    wait_until(l);
    locked = 1'b1;
    run_t = l + 3 + S;
    push(run_t, vec(1, 1, 1, 0, 0));
    drain("boot");
    chk("boot_count", lock_loss_count, 8'd0);
    locked = 1'b0;
    reset_pulse(k);
    w = k + RST;
    for (int i = 0; i < MR; i++) begin
      push(w + LT, vec(0, 0, 0, 0, 0));
      w = w + LT + RST;
      push(w, vec(1, 0, 0, 0, 0));
    end
    push(w + LT, vec(0, 0, 0, 1, 0));
    r = w + LT + int'($urandom_range(5, 0));
    wait_until(r);
    relock_req = 1'b1;
    push(r + 1, vec(0, 0, 0, 0, 0));
    push(r + 1 + RST, vec(1, 0, 0, 0, 0));
    step;
    relock_req = 1'b0;
    locked = 1'b1;
    run_t = r + 2 + RST + S;
    push(run_t, vec(1, 1, 1, 0, 0));
    drain("fault_exit");
    for (int i = 0; i < 3; i++) begin
      locked = 1'b0;
      reset_pulse(k);
      l = k + int'($urandom_range(20, 2));
      wait_until(l);
      locked = 1'b1;
      d = l + (i == 0 ? 5 : int'($urandom_range(S - 1, 1)));
      wait_until(d);
      locked = 1'b0;
      step;
      locked = 1'b1;
      run_t = d + 4 + S;
      push(run_t, vec(1, 1, 1, 0, 0));
      drain("stable_dip");
      chk("dip_count", lock_loss_count, 8'd0);
    end
    for (int i = 0; i < 300; i++) run_drop(1'b0);
    drain("drops");
    chk("sat_count", lock_loss_count, 8'd255);
    reset_pulse(k);
    run_t = k + RST + 1 + S;
    push(run_t, vec(1, 1, 1, 0, 0));
    run_drop(1'b1);
    drain("relock_and_drop");
    chk("combined_count", lock_loss_count, 8'd1);
    relock_enter(qt);
    pulse_relock(qt + 3);
    pulse_relock(qt + RST + 1);
    pulse_relock(qt + RST + 4);
    run_t = qt + 2 + RST + S;
    push(run_t, vec(1, 1, 1, 0, cnt_m));
    drain("relock_only");
    chk("relock_count", lock_loss_count, 8'd1);
    relock_enter(qt);
    wait_until(qt + 2 + RST + int'($urandom_range(S - 2, 0)));
    reset_pulse(k);
    run_t = k + RST + 1 + S;
    push(run_t, vec(1, 1, 1, 0, 0));
    drain("mid_reset");
    chk("final_count", lock_loss_count, 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 The block SHALL expose parameters (name, default, meaning), one per line:
- RST_CYCLES, 16: cycles pll_resetb is held low per PLL reset.
- LOCK_TIMEOUT, 4096: cycles allowed in WAIT_LOCK before a retry.
- STABLE_CYCLES, 256: consecutive synchronized-lock cycles required before release.
- MAX_RETRIES, 3: timeouts tolerated before FAULT.
- CNT_W, 16: internal counter width; SHALL satisfy 2^CNT_W > max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).
REQ-002 The block SHALL have one clock and a synchronous, active-low reset; ports (name, direction, width, meaning) are:
- clk, in, 1: free-running reference clock (the PLL input clock).
- sresetn, in, 1: synchronous active-low reset.
- locked, in, 1: PLL lock indication, asynchronous to clk.
- relock_req, in, 1: single-cycle request to restart the PLL.
- pll_resetb, out, 1: drives PLL RESETB; low holds the PLL in reset.
- sys_resetn, out, 1: downstream synchronous active-low reset.
- ready, out, 1: high in RUN.
- fault, out, 1: high in FAULT.
- lock_loss_count, out, 8: saturating count of lock losses seen in RUN.

Function
REQ-003 locked SHALL pass through a two-flop synchronizer (lock_s) before any use.
REQ-004 The FSM SHALL have states PLL_RST, WAIT_LOCK, STABLE, RUN and FAULT; all outputs SHALL be registered.
REQ-005 PLL_RST: pll_resetb=0 for exactly RST_CYCLES cycles, then go to WAIT_LOCK.
REQ-006 WAIT_LOCK: pll_resetb=1. lock_s=1 -> STABLE. Timeout counter reaching LOCK_TIMEOUT-1 with lock_s=0 -> retry_cnt+1 and PLL_RST. If retry_cnt already equals MAX_RETRIES -> FAULT instead.
REQ-007 STABLE: count consecutive lock_s=1 cycles. lock_s=0 -> WAIT_LOCK with the stable and timeout counters cleared, and no lock_loss_count change. After STABLE_CYCLES cycles -> RUN with retry_cnt cleared.
REQ-008 With locked held high, sys_resetn and ready SHALL rise exactly STABLE_CYCLES+3 clk edges after locked rises: 2 synchronizer edges, 1 entry edge, then STABLE_CYCLES edges.
REQ-009 RUN: sys_resetn=1, ready=1. lock_s=0 -> sys_resetn=0 and ready=0 on the next edge, lock_loss_count+1 (saturating at 255), go to PLL_RST.
REQ-010 relock_req in RUN -> PLL_RST with no count change. If relock_req and lock_s=0 occur in the same RUN cycle, the event SHALL be treated as a lock loss (count increments).
REQ-011 relock_req in PLL_RST, WAIT_LOCK or STABLE SHALL be ignored.
REQ-012 FAULT: pll_resetb=0, sys_resetn=0, fault=1. Only relock_req exits FAULT: clear retry_cnt and fault, go to PLL_RST.
REQ-013 sys_resetn SHALL be 0 in every state except RUN; pll_resetb SHALL be 0 only in PLL_RST and FAULT.
REQ-014 lock_loss_count SHALL be cleared only by sresetn.

Reset
REQ-015 While sresetn=0 at a clk edge: state=PLL_RST with counter 0, pll_resetb=0, sys_resetn=0, ready=0, fault=0, lock_loss_count=0, retry_cnt=0, synchronizer flops=0.
REQ-016 Reset asserted mid-operation (any state) SHALL take effect at the next edge and restart the full sequence, including a full RST_CYCLES hold.

Structure
REQ-017 A shared package pll_seq_pkg SHALL hold the state enumeration and the default parameter constants.
REQ-018 The synchronizer SHALL be a sub-module named bit_sync (2 flops, reset to 0); all other logic SHALL live in pll_reset_sequencer.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2)
REQ-019 The bench SHALL cover:
- Reset release, then locked rises 10 cycles later -> pll_resetb low for 4 cycles; sys_resetn rises 11 edges after locked rises; lock_loss_count=0.
- locked never asserts -> 3 PLL_RST pulses of 4 cycles each, then fault=1, pll_resetb=0; relock_req -> fault=0 and a new 4-cycle PLL_RST.
- locked drops for 1 cycle in STABLE (cycle 5) -> STABLE restarts; sys_resetn rises 8+1 cycles after lock_s returns; count stays 0.
- locked drops in RUN 300 times -> each drop gives sys_resetn low within 3 edges; lock_loss_count saturates at 255.
- relock_req and lock drop in the same RUN cycle -> count increments by exactly 1; relock_req alone -> count unchanged, PLL_RST entered.
- sresetn pulsed low during STABLE -> all outputs return to reset values next edge, with a full 4-cycle pll_resetb low after release.
